// File: rtl/add_sub_zero_result_responder_pkg.sv
// Shared definitions for the add/sub zero-result responder: state encoding,
// precision widths and the timeout defaults.
package add_sub_zero_result_responder_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CHECK   = 3'd2,
    S_WAIT_DP = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  localparam int W_SINGLE        = 32;
  localparam int W_DOUBLE        = 64;
  localparam int TIMEOUT_DEFAULT = 16;

  // Counter must be able to hold TIMEOUT itself, hence the +1.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/add_sub_zero_result_responder_timeout.sv
// Cycle counter for the datapath wait; flags the last permitted wait cycle
// (count == TIMEOUT-1).
module add_sub_timeout_counter
  import add_sub_zero_result_responder_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CW      = cnt_width(TIMEOUT_DEFAULT)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_terminal = (r_count == TC);

endmodule

// File: rtl/add_sub_zero_result_responder.sv
// Consumer end of the add/sub zero-detection path: strobes the zero-detect
// load, then returns +0 directly or waits (bounded) for the datapath result.
module add_sub_zero_result_responder
  import add_sub_zero_result_responder_pkg::*;
#(
  parameter int W       = W_SINGLE,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  input  logic         arit_op,
  output logic         load_zero,
  input  logic         zero_flag,
  input  logic [W-1:0] dp_result,
  input  logic         dp_valid,
  output logic         dp_flush,
  output logic [W-1:0] result,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         zero_out,
  output logic         timeout_err
);

  localparam int CW = cnt_width(TIMEOUT);

  state_t         r_state;
  logic           r_ready;
  logic           r_load_zero;
  logic [W-1:0]   r_result;
  logic           r_result_valid;
  logic           r_zero_out;
  logic           r_timeout_err;
  logic           r_arit_op;

  logic           w_cnt_clear;
  logic           w_cnt_enable;
  logic           w_terminal;
  logic           w_zero_hit;
  logic           w_timeout_hit;
  logic           w_unused_op;

  assign w_cnt_clear  = (r_state == S_CHECK);
  assign w_cnt_enable = (r_state == S_WAIT_DP);

  add_sub_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_cnt_clear),
    .i_enable   (w_cnt_enable),
    .o_terminal (w_terminal)
  );

  // The zero flag only becomes valid in CHECK, so the flush that abandons the
  // datapath must be decoded in that same cycle rather than a cycle later.
  assign w_zero_hit    = (r_state == S_CHECK) && zero_flag;
  assign w_timeout_hit = (r_state == S_WAIT_DP) && !dp_valid && w_terminal;
  assign dp_flush      = w_zero_hit || w_timeout_hit;

  // An exact-cancellation zero is +0 for both add and subtract under
  // round-to-nearest, so the captured op does not steer the result today.
  assign w_unused_op = r_arit_op;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_ready        <= 1'b1;
      r_load_zero    <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_zero_out     <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_arit_op      <= 1'b0;
    end else begin
      r_load_zero <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_arit_op     <= arit_op;
            r_timeout_err <= 1'b0;
            r_ready       <= 1'b0;
            r_load_zero   <= 1'b1;
            r_state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (zero_flag) begin
            r_result       <= '0;
            r_zero_out     <= 1'b1;
            r_result_valid <= 1'b1;
            r_state        <= S_OUT;
          end else if (dp_valid) begin
            r_result       <= dp_result;
            r_zero_out     <= 1'b0;
            r_result_valid <= 1'b1;
            r_state        <= S_OUT;
          end else begin
            r_state <= S_WAIT_DP;
          end
        end
        S_WAIT_DP: begin
          if (dp_valid) begin
            r_result       <= dp_result;
            r_zero_out     <= 1'b0;
            r_result_valid <= 1'b1;
            r_state        <= S_OUT;
          end else if (w_terminal) begin
            r_timeout_err <= 1'b1;
            r_ready       <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        S_OUT: begin
          if (result_ready) begin
            r_result_valid <= 1'b0;
            r_ready        <= 1'b1;
            r_state        <= S_IDLE;
          end
        end
        default: begin
          r_result_valid <= 1'b0;
          r_ready        <= 1'b1;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

  assign ready        = r_ready;
  assign load_zero    = r_load_zero;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign zero_out     = r_zero_out;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_add_sub_zero_result_responder.sv
// Directed bench for add_sub_zero_result_responder: a vector table of whole
// operations plus hand-written reset, back-pressure and timeout sequences.
module tb_add_sub_zero_result_responder;

  localparam int W       = 32;
  localparam int TIMEOUT = 16;
  localparam int NEVER   = -1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         arit_op = 1'b0;
  logic         zero_flag = 1'b0;
  logic [W-1:0] dp_result = '0;
  logic         dp_valid = 1'b0;
  logic         result_ready = 1'b0;
  logic         ready;
  logic         load_zero;
  logic         dp_flush;
  logic [W-1:0] result;
  logic         result_valid;
  logic         zero_out;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_sub_zero_result_responder #(
    .W       (W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ready        (ready),
    .arit_op      (arit_op),
    .load_zero    (load_zero),
    .zero_flag    (zero_flag),
    .dp_result    (dp_result),
    .dp_valid     (dp_valid),
    .dp_flush     (dp_flush),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .zero_out     (zero_out),
    .timeout_err  (timeout_err)
  );

  // Cycle 1 is LOAD, cycle 2 is CHECK, WAIT_DP cycle n is cycle 2+n.
  // dpCycle: 0 = dp_valid in CHECK, n = in WAIT_DP cycle n, NEVER = none.
  typedef struct {
    string        name;
    logic         isSub;
    logic         zflag;
    int           dpCycle;
    logic [W-1:0] dpData;
    logic         expValid;
    int           expValidCycle;
    logic [W-1:0] expResult;
    logic         expZero;
    logic         expTimeout;
    int           expFlushCycle;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int           flushCycle;
    int           validCycle;
    int           loadCount;
    logic         overlap;
    logic         done;
    logic [W-1:0] gotResult;
    logic         gotZero;
    @(negedge clk);
    start        = 1'b1;
    arit_op      = v.isSub;
    zero_flag    = 1'b0;
    dp_valid     = 1'b0;
    result_ready = 1'b1;
    #1;
    checkOutput({v.name, " readyIdle"}, ready, 1);
    flushCycle = 0;
    validCycle = 0;
    loadCount  = 0;
    overlap    = 1'b0;
    done       = 1'b0;
    gotResult  = '0;
    gotZero    = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      start     = 1'b0;
      zero_flag = (c >= 2) ? v.zflag : 1'b0;
      dp_valid  = (v.dpCycle >= 0) && (c == 2 + v.dpCycle);
      dp_result = dp_valid ? v.dpData : 32'hDEAD_BEEF;
      #1;
      if (c == 1) checkOutput({v.name, " errClearedOnAccept"}, timeout_err, 0);
      if (load_zero) loadCount++;
      if (load_zero && dp_flush) overlap = 1'b1;
      if (dp_flush && flushCycle == 0) flushCycle = c;
      if (result_valid) begin
        validCycle = c;
        gotResult  = result;
        gotZero    = zero_out;
        done       = 1'b1;
      end else if (ready) begin
        done = 1'b1;
      end
    end
    dp_valid  = 1'b0;
    zero_flag = 1'b0;
    checkOutput({v.name, " validCycle"}, validCycle, v.expValid ? v.expValidCycle : 0);
    if (v.expValid) begin
      checkOutput({v.name, " result"}, gotResult, v.expResult);
      checkOutput({v.name, " zeroOut"}, gotZero, v.expZero);
    end
    checkOutput({v.name, " flushCycle"}, flushCycle, v.expFlushCycle);
    checkOutput({v.name, " loadPulses"}, loadCount, 1);
    checkOutput({v.name, " loadFlushOverlap"}, overlap, 0);
    @(negedge clk);
    #1;
    checkOutput({v.name, " readyAfter"}, ready, 1);
    checkOutput({v.name, " validAfter"}, result_valid, 0);
    checkOutput({v.name, " timeoutErr"}, timeout_err, v.expTimeout);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] heldResult;
    int           holdBad;

    vecs[0] = '{"zeroPath",      1'b0, 1'b1, NEVER, 32'h0000_0000, 1'b1, 3,  32'h0000_0000, 1'b1, 1'b0, 2};
    vecs[1] = '{"zeroIgnoresDp", 1'b1, 1'b1, 0,     32'h1234_5678, 1'b1, 3,  32'h0000_0000, 1'b1, 1'b0, 2};
    vecs[2] = '{"dpInCheck",     1'b0, 1'b0, 0,     32'hC049_0FDB, 1'b1, 3,  32'hC049_0FDB, 1'b0, 1'b0, 0};
    vecs[3] = '{"dpWait4",       1'b0, 1'b0, 4,     32'h4040_0000, 1'b1, 7,  32'h4040_0000, 1'b0, 1'b0, 0};
    vecs[4] = '{"dpWait1NegZ",   1'b1, 1'b0, 1,     32'h8000_0000, 1'b1, 4,  32'h8000_0000, 1'b0, 1'b0, 0};
    vecs[5] = '{"timeout",       1'b0, 1'b0, NEVER, 32'h0000_0000, 1'b0, 0,  32'h0000_0000, 1'b0, 1'b1, 18};
    vecs[6] = '{"afterTimeout",  1'b1, 1'b0, 2,     32'hFFFF_FFFF, 1'b1, 5,  32'hFFFF_FFFF, 1'b0, 1'b0, 0};
    vecs[7] = '{"dpAtTerminal",  1'b0, 1'b0, 16,    32'h3F80_0000, 1'b1, 19, 32'h3F80_0000, 1'b0, 1'b0, 0};
    vecs[8] = '{"dpWait15",      1'b1, 1'b0, 15,    32'h7F7F_FFFF, 1'b1, 18, 32'h7F7F_FFFF, 1'b0, 1'b0, 0};

    #2 rst = 1'b0;
    #1;
    checkOutput("reset ready", ready, 1);
    checkOutput("reset resultValid", result_valid, 0);
    checkOutput("reset loadZero", load_zero, 0);
    checkOutput("reset dpFlush", dp_flush, 0);
    checkOutput("reset timeoutErr", timeout_err, 0);
    checkOutput("reset zeroOut", zero_out, 0);
    checkOutput("reset result", result, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Back-pressure: result held for 5 cycles with stray starts, taken on the 6th.
    @(negedge clk);
    start = 1'b1; arit_op = 1'b0; result_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dp_valid = 1'b1; dp_result = 32'hA5A5_A5A5;
    @(negedge clk);
    dp_valid = 1'b0; dp_result = 32'hDEAD_BEEF;
    #1;
    checkOutput("bp validAtCycle3", result_valid, 1);
    heldResult = result;
    checkOutput("bp result", heldResult, 32'hA5A5_A5A5);
    checkOutput("bp zeroOut", zero_out, 0);
    holdBad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      start    = (i % 2 == 0);
      dp_valid = (i == 2);
      dp_result = (i == 2) ? 32'h1111_1111 : 32'hDEAD_BEEF;
      #1;
      if (!result_valid || result !== 32'hA5A5_A5A5 || ready || load_zero) holdBad++;
    end
    checkOutput("bp heldStable", holdBad, 0);
    @(negedge clk);
    start = 1'b0; dp_valid = 1'b0; result_ready = 1'b1;
    #1;
    checkOutput("bp validOn6th", result_valid, 1);
    @(negedge clk);
    result_ready = 1'b0;
    #1;
    checkOutput("bp readyAfterAccept", ready, 1);
    checkOutput("bp validDropped", result_valid, 0);
    @(negedge clk);
    #1;
    checkOutput("bp startNotQueued", load_zero, 0);

    // Asynchronous reset while waiting on the datapath.
    @(negedge clk);
    start = 1'b1; zero_flag = 1'b0; result_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    checkOutput("rstMid busyBefore", ready, 0);
    rst = 1'b0;
    #1;
    checkOutput("rstMid ready", ready, 1);
    checkOutput("rstMid resultValid", result_valid, 0);
    checkOutput("rstMid timeoutErr", timeout_err, 0);
    checkOutput("rstMid dpFlush", dp_flush, 0);
    checkOutput("rstMid loadZero", load_zero, 0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(vecs[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
